// File: rtl/issue_scheduler.sv
// issue_scheduler: single-issue in-order dispatch stage between fetch and the
// ALU, BRU and MAU execution units.
//
// One instruction sits in the issue slot. It is decoded combinationally into
// rd/rs1/rs2/immediate and unit select, and checked against a 32-entry
// scoreboard of pending register writes. It is then dispatched over a
// valid/ready handshake. HALT drains the scoreboard and then stops the stage.
// Undecodable words stop the stage with illegal set.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   instr_valid/instr/instr_pc    fetch offer;  instr_ready: slot accepts
//   {alu,bru,mau}_valid/_ready    dispatch handshake per execution unit
//   issue_instr/pc/rd/rs1/rs2/imm slot contents and decoded fields
//   wb_valid/wb_rd                register write retiring (clears scoreboard)
//   flush                         BRU redirect, discards the slot
//   sb_busy                       any scoreboard bit set
//   halted / illegal              sticky status until reset
module issue_scheduler #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  output logic            instr_ready,
  output logic            alu_valid,
  output logic            bru_valid,
  output logic            mau_valid,
  input  logic            alu_ready,
  input  logic            bru_ready,
  input  logic            mau_ready,
  output logic [31:0]     issue_instr,
  output logic [XLEN-1:0] issue_pc,
  output logic [4:0]      issue_rd,
  output logic [4:0]      issue_rs1,
  output logic [4:0]      issue_rs2,
  output logic [XLEN-1:0] issue_imm,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            sb_busy,
  output logic            halted,
  output logic            illegal
);

  localparam logic [31:0] HALT_WORD = 32'h0001_0073;

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERROR} state_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

  function automatic logic is_alu_op(input logic [31:0] w);
    case (w[6:0])
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch_op(input logic [31:0] w);
    case (w[6:0])
      7'b1100011, 7'b1101111, 7'b1100111: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_memory_op(input logic [31:0] w);
    case (w[6:0])
      7'b0000011, 7'b0100011: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic fmt_e get_fmt(input logic [31:0] w);
    case (w[6:0])
      7'b0110011:                         return FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: return FMT_I;
      7'b0100011:                         return FMT_S;
      7'b1100011:                         return FMT_B;
      7'b0110111, 7'b0010111:             return FMT_U;
      7'b1101111:                         return FMT_J;
      default:                            return FMT_NONE;
    endcase
  endfunction

  function automatic logic [31:0] get_imm(input logic [31:0] w, input fmt_e f);
    case (f)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'h000};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  // State
  state_e            state_q, state_d;
  logic              slot_valid_q, slot_valid_d;
  logic [31:0]       slot_instr_q, slot_instr_d;
  logic [XLEN-1:0]   slot_pc_q, slot_pc_d;
  logic [31:0]       sb_q, sb_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  // Decode
  fmt_e        fmt;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        writes_rd;
  logic        sel_alu, sel_bru, sel_mau;
  logic        is_halt;
  logic        hazard;
  logic        run;
  logic        dispatch_ok;
  logic        fire;
  logic        accept;
  logic        enter_halt;

  always_comb begin
    fmt       = get_fmt(slot_instr_q);
    writes_rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    dec_rd    = writes_rd ? slot_instr_q[11:7] : '0;
    dec_rs1   = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? slot_instr_q[19:15] : '0;
    dec_rs2   = (fmt inside {FMT_R, FMT_S, FMT_B})        ? slot_instr_q[24:20] : '0;
    dec_imm   = get_imm(slot_instr_q, fmt);
    sel_alu   = is_alu_op(slot_instr_q);
    sel_bru   = is_branch_op(slot_instr_q);
    sel_mau   = is_memory_op(slot_instr_q);
    is_halt   = (slot_instr_q == HALT_WORD);

    // Absent fields decode to 0, so x0 checks also cover "field absent".
    // Scoreboard is read registered only: a write-back unblocks next cycle.
    hazard = ((dec_rs1 != '0) && sb_q[dec_rs1]) ||
             ((dec_rs2 != '0) && sb_q[dec_rs2]) ||
             ((dec_rd  != '0) && sb_q[dec_rd]);

    run         = (state_q == ST_RUN);
    dispatch_ok = slot_valid_q && run && !hazard && !flush;
    alu_valid   = dispatch_ok && sel_alu;
    bru_valid   = dispatch_ok && sel_bru;
    mau_valid   = dispatch_ok && sel_mau;
    fire        = (alu_valid && alu_ready) || (bru_valid && bru_ready) ||
                  (mau_valid && mau_ready);

    // reset_n gates ready so every output is 0 while reset is held, even
    // though the reset state (RUN, empty slot) would otherwise accept.
    instr_ready = reset_n && run && (!slot_valid_q || fire) && !flush;
    accept      = instr_valid && instr_ready;
  end

  // Next state: FSM, status, slot, scoreboard
  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    enter_halt = 1'b0;

    // A flushed slot is on the wrong path, so it cannot halt or trap.
    if (run && slot_valid_q && !flush) begin
      if (is_halt) begin
        if (sb_q == '0) begin
          state_d    = ST_HALTED;
          halted_d   = 1'b1;
          enter_halt = 1'b1;
        end
      end else if (!(sel_alu || sel_bru || sel_mau)) begin
        state_d   = ST_ERROR;
        illegal_d = 1'b1;
      end
    end

    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    if (flush) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_valid_d = 1'b1;
      slot_instr_d = instr;
      slot_pc_d    = instr_pc;
    end else if (fire || enter_halt) begin
      slot_valid_d = 1'b0;
    end

    // Clear before set so a same-cycle set of the same register wins.
    sb_d = sb_q;
    if (wb_valid && (wb_rd != '0)) sb_d[wb_rd] = 1'b0;
    if (fire && writes_rd && (dec_rd != '0)) sb_d[dec_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      sb_q         <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      sb_q         <= sb_d;
    end
  end

  assign issue_instr = slot_instr_q;
  assign issue_pc    = slot_pc_q;
  assign issue_rd    = dec_rd;
  assign issue_rs1   = dec_rs1;
  assign issue_rs2   = dec_rs2;
  assign issue_imm   = XLEN'($signed(dec_imm));
  assign sb_busy     = |sb_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed testbench for issue_scheduler with hand-computed expectations.
module tb_issue_scheduler;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] ADD_X2  = 32'h0010_8133;  // add  x2,x1,x1
  localparam logic [31:0] LW_X3   = 32'h0000_2183;  // lw   x3,0(x0)
  localparam logic [31:0] HALT    = 32'h0001_0073;
  localparam logic [31:0] BAD     = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            alu_valid, bru_valid, mau_valid;
  logic            alu_ready, bru_ready, mau_ready;
  logic [31:0]     issue_instr;
  logic [XLEN-1:0] issue_pc;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic [XLEN-1:0] issue_imm;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic            sb_busy, halted, illegal;

  int tests = 0;
  int fails = 0;

  issue_scheduler #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .alu_valid(alu_valid), .bru_valid(bru_valid), .mau_valid(mau_valid),
    .alu_ready(alu_ready), .bru_ready(bru_ready), .mau_ready(mau_ready),
    .issue_instr(issue_instr), .issue_pc(issue_pc),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_imm(issue_imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .sb_busy(sb_busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change only after this.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_ready"},  instr_ready, 0);
    chk_eq({tag, "_valids"}, {alu_valid, bru_valid, mau_valid}, 0);
    chk_eq({tag, "_busy"},   sb_busy, 0);
    chk_eq({tag, "_halted"}, halted, 0);
    chk_eq({tag, "_illegal"}, illegal, 0);
    chk_eq({tag, "_instr"},  issue_instr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; instr = '0; instr_pc = '0;
    alu_ready = 1'b0; bru_ready = 1'b0; mau_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    #2;
    chk_all_zero("rst");
    #10 reset_n = 1'b1;

    // 1: ADDI x1 dispatches the cycle after accept and sets sb[1]
    cyc();
    instr_valid = 1'b1; instr = ADDI_X1; instr_pc = 32'h100; alu_ready = 1'b1;
    #1 chk_eq("t1_ready", instr_ready, 1);
    cyc();
    instr_valid = 1'b0;
    #1;
    chk_eq("t1_alu_valid", alu_valid, 1);
    chk_eq("t1_other_valid", {bru_valid, mau_valid}, 0);
    chk_eq("t1_rd", issue_rd, 1);
    chk_eq("t1_rs1", issue_rs1, 0);
    chk_eq("t1_imm", issue_imm, 5);
    chk_eq("t1_pc", issue_pc, 32'h100);
    chk_eq("t1_busy_pre", sb_busy, 0);
    cyc();
    #1;
    chk_eq("t1_alu_done", alu_valid, 0);
    chk_eq("t1_busy", sb_busy, 1);
    wb_valid = 1'b1; wb_rd = 5'd1;
    cyc();
    wb_valid = 1'b0;
    #1 chk_eq("t1_busy_clr", sb_busy, 0);

    // 2: RAW stall of ADD on x1, released one cycle after write-back
    instr_valid = 1'b1; instr = ADDI_X1;
    cyc();
    instr = ADD_X2;
    #1;
    chk_eq("t2_addi_valid", alu_valid, 1);
    chk_eq("t2_ready_fire", instr_ready, 1);
    cyc();
    instr_valid = 1'b0;
    #1;
    chk_eq("t2_stall", alu_valid, 0);
    chk_eq("t2_stall_ready", instr_ready, 0);
    chk_eq("t2_rd", issue_rd, 2);
    cyc();
    #1 chk_eq("t2_stall2", alu_valid, 0);
    wb_valid = 1'b1; wb_rd = 5'd1;
    #1 chk_eq("t2_no_bypass", alu_valid, 0);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk_eq("t2_release", alu_valid, 1);
    chk_eq("t2_rs1", issue_rs1, 1);
    chk_eq("t2_rs2", issue_rs2, 1);
    cyc();
    #1;
    chk_eq("t2_done", alu_valid, 0);
    chk_eq("t2_busy", sb_busy, 1);
    wb_valid = 1'b1; wb_rd = 5'd2;
    cyc();
    wb_valid = 1'b0;
    #1 chk_eq("t2_busy_clr", sb_busy, 0);

    // 3: LW held by mau_ready=0 for 3 cycles, stable outputs, sb[3] on fire
    instr_valid = 1'b1; instr = LW_X3; instr_pc = 32'h200;
    cyc();
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_eq("t3_mau_valid", mau_valid, 1);
      chk_eq("t3_instr", issue_instr, LW_X3);
      chk_eq("t3_rd", issue_rd, 3);
      chk_eq("t3_pc", issue_pc, 32'h200);
      chk_eq("t3_busy_hold", sb_busy, 0);
      cyc();
    end
    mau_ready = 1'b1;
    #1 chk_eq("t3_mau_fire", mau_valid, 1);
    cyc();
    mau_ready = 1'b0;
    #1;
    chk_eq("t3_done", mau_valid, 0);
    chk_eq("t3_busy", sb_busy, 1);
    wb_valid = 1'b1; wb_rd = 5'd3;
    cyc();
    wb_valid = 1'b0;
    #1 chk_eq("t3_busy_clr", sb_busy, 0);

    // 4: same-cycle set and clear of x1, set wins
    instr_valid = 1'b1; instr = ADDI_X1;
    cyc();
    instr_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd1;
    #1 chk_eq("t4_alu_valid", alu_valid, 1);
    cyc();
    wb_valid = 1'b0;
    #1 chk_eq("t4_set_wins", sb_busy, 1);
    wb_valid = 1'b1; wb_rd = 5'd1;
    cyc();
    wb_valid = 1'b0;
    #1 chk_eq("t4_busy_clr", sb_busy, 0);

    // 5: HALT waits for the scoreboard to drain, then sticks until reset
    instr_valid = 1'b1; instr = ADDI_X1;
    cyc();
    instr = HALT;
    #1 chk_eq("t5_ready", instr_ready, 1);
    cyc();
    instr_valid = 1'b0;
    #1;
    chk_eq("t5_wait_halted", halted, 0);
    chk_eq("t5_wait_ready", instr_ready, 0);
    chk_eq("t5_no_dispatch", {alu_valid, bru_valid, mau_valid}, 0);
    cyc();
    cyc();
    #1 chk_eq("t5_wait2_halted", halted, 0);
    wb_valid = 1'b1; wb_rd = 5'd1;
    cyc();
    wb_valid = 1'b0;
    #1 chk_eq("t5_drain_halted", halted, 0);
    cyc();
    #1 chk_eq("t5_halted", halted, 1);
    instr_valid = 1'b1; instr = ADDI_X1;
    #1 chk_eq("t5_halt_ready", instr_ready, 0);
    cyc();
    cyc();
    #1;
    chk_eq("t5_halted_sticky", halted, 1);
    chk_eq("t5_ready_sticky", instr_ready, 0);
    chk_eq("t5_valid_sticky", {alu_valid, bru_valid, mau_valid}, 0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("t5_rst");
    instr_valid = 1'b0;
    #1 reset_n = 1'b1;

    // 6a: illegal word traps, nothing dispatched
    cyc();
    instr_valid = 1'b1; instr = BAD;
    cyc();
    instr_valid = 1'b0;
    #1 chk_eq("t6a_no_valid", {alu_valid, bru_valid, mau_valid}, 0);
    cyc();
    instr_valid = 1'b1; instr = ADDI_X1;
    #1;
    chk_eq("t6a_illegal", illegal, 1);
    chk_eq("t6a_no_valid2", {alu_valid, bru_valid, mau_valid}, 0);
    chk_eq("t6a_ready", instr_ready, 0);
    instr_valid = 1'b0;
    reset_n = 1'b0;
    #1 chk_eq("t6a_rst_illegal", illegal, 0);
    reset_n = 1'b1;

    // 6b: flush a stalled ADD; scoreboard keeps the pending x1 write
    cyc();
    instr_valid = 1'b1; instr = ADDI_X1;
    cyc();
    instr = ADD_X2;
    cyc();
    instr_valid = 1'b0;
    #1 chk_eq("t6b_stall", alu_valid, 0);
    flush = 1'b1; instr_valid = 1'b1; instr = LW_X3;
    #1 chk_eq("t6b_flush_ready", instr_ready, 0);
    cyc();
    flush = 1'b0; instr_valid = 1'b0;
    #1;
    chk_eq("t6b_busy", sb_busy, 1);
    chk_eq("t6b_no_valid", {alu_valid, bru_valid, mau_valid}, 0);
    wb_valid = 1'b1; wb_rd = 5'd1;
    cyc();
    wb_valid = 1'b0;
    #1;
    chk_eq("t6b_busy_clr", sb_busy, 0);
    chk_eq("t6b_slot_empty", {alu_valid, bru_valid, mau_valid}, 0);
    chk_eq("t6b_ready", instr_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Single-issue in-order dispatch stage between fetch and the three execution units (ALU, BRU, MAU).
- Holds one instruction in an issue slot and decodes its format, unit, rd, rs1, rs2 and immediate using the opcodes package functions.
- Tracks pending register writes in a 32-entry scoreboard, stalls on RAW/WAW hazards and dispatches to the selected unit over a valid/ready handshake.
- Detects HALT and illegal encodings.

Parameters:
XLEN, 32, datapath width; sets the width of the PC and immediate outputs.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  fetch offers an instruction
instr  in  32  instruction word (instruction_t)
instr_pc  in  XLEN  PC of the offered instruction
instr_ready  out  1  slot can accept the offered instruction this cycle
alu_valid / bru_valid / mau_valid  out  1 each  dispatch request to the unit
alu_ready / bru_ready / mau_ready  in  1 each  unit accepts the dispatch
issue_instr  out  32  slot instruction word
issue_pc  out  XLEN  slot PC
issue_rd / issue_rs1 / issue_rs2  out  5 each  decoded register numbers; 0 when the field is absent
issue_imm  out  XLEN  decoded immediate, sign-extended
wb_valid  in  1  a unit retires a register write
wb_rd  in  5  destination register of the retiring write
flush  in  1  BRU redirect; discard the slot contents
sb_busy  out  1  at least one scoreboard bit is set
halted  out  1  HALT retired; sticky until reset
illegal  out  1  undecodable instruction reached the slot; sticky until reset

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- During reset the slot is empty and the scoreboard is cleared.
- The FSM returns to RUN and every output drives 0.

FSM states: RUN, HALTED, ERROR.
- RUN to HALTED: the slot holds HALT (32'h00010073) and the scoreboard is all-zero. The slot is cleared and halted=1.
- RUN to ERROR: the slot holds a word for which is_alu_op, is_branch_op and is_memory_op are all 0, and the word is not HALT. Set illegal=1.
- HALTED and ERROR are absorbing. In both states instr_ready=0 and all *_valid=0.

Accept:
- instr_ready = (state==RUN) & (slot empty | fire) & !flush.
- Accept when instr_valid & instr_ready. The slot loads at the edge.
- Earliest dispatch is the next cycle, so dispatch latency is 1 cycle.

Dispatch:
- Decode is combinational from the slot register.
- hazard = (rs1!=0 & sb[rs1]) | (rs2!=0 & sb[rs2]) | (writes_rd & rd!=0 & sb[rd]).
- The scoreboard is read from the registered value. There is no same-cycle bypass of wb, so a cleared bit unblocks the slot one cycle later.
- unit_valid = slot valid & state==RUN & !hazard & !flush & the unit matches. Exactly one *_valid may be high at a time.
- fire = unit_valid & unit_ready. On fire the slot empties unless a new instruction is accepted in the same cycle.
- issue_* outputs must be stable while *_valid is high and ready is low.
- HALT is never dispatched.

Scoreboard:
- writes_rd is true for R-, I-, U- and J-type instructions, which covers loads and JALR. Stores and branches never set a bit.
- On fire with writes_rd & rd!=0, set sb[rd].
- On wb_valid, clear sb[wb_rd]. A write-back to x0 is ignored.
- If the same register is set and cleared in the same cycle, the set wins.

Immediate:
- issue_imm is the get_imm value sign-extended to XLEN.
- U-type immediate is imm20<<12.
- R-type immediate is 0.

Flush:
- When flush is high, the slot is cleared at the edge.
- No dispatch and no accept occur in that cycle.
- The scoreboard is unchanged, because in-flight writes still retire.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), alu_ready=1 -> alu_valid in the cycle after accept; issue_rd=1, issue_imm=5; sb[1]=1 and sb_busy=1.
2. ADDI x1 then ADD x2,x1,x1 (0x00108133), no wb -> ADD held with alu_valid=0 and instr_ready=0; assert wb_valid with wb_rd=1 -> ADD dispatches one cycle later.
3. LW x3,0(x0) (0x00002183) with mau_ready=0 for 3 cycles -> mau_valid=1 with issue_* stable for all 3 cycles; dispatches on the cycle mau_ready=1; sb[3] sets only then.
4. wb_valid with wb_rd=1 in the same cycle that ADDI x1 fires -> sb[1] remains 1.
5. ADDI x1 pending, then HALT -> halted=0 until wb_rd=1 retires; then halted=1 and instr_ready=0 permanently. Assert reset_n=0 mid-sequence -> all outputs return to 0 immediately.
6. Two further checks:
   - Word 0xFFFFFFFF -> illegal=1 and no *_valid asserted.
   - flush with a stalled instruction in the slot -> slot cleared and the scoreboard unchanged.
